// File: rtl/bounce_gen_pkg.sv
// Shared definitions for the bouncy-button waveform generator:
// FSM state encoding, LFSR tap mask, default seed and LFSR helper functions.
package bounce_gen_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    DONE       = 3'd4
  } bounce_state_t;

  // Galois tap mask for x^8 + x^6 + x^5 + x^4 + 1 (right-shifting form).
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  function automatic logic [7:0] fix_seed(input logic [7:0] seed);
    fix_seed = (seed == 8'h00) ? 8'h01 : seed;
  endfunction

  // One step of the Galois LFSR.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 8-bit Galois LFSR used to randomise bounce segment lengths.
// Only present in builds with BUTTON_BOUNCE_GEN_RANDOM_EN defined; the
// deterministic build has no LFSR at all.
`ifdef BUTTON_BOUNCE_GEN_RANDOM_EN
module bounce_lfsr
  import bounce_gen_pkg::*;
#(
  parameter logic [7:0] SEED = DEFAULT_SEED
) (
  input  logic       logicclk,
  input  logic       clr,
  input  logic       enable,
  input  logic       load,
  output logic [7:0] state
);

  localparam logic [7:0] SEED_EFF = fix_seed(SEED);

  // Seed on reset or explicit load, otherwise step while enabled.
  always_ff @(posedge logicclk or posedge clr) begin
    if (clr) begin
      state <= SEED_EFF;
    end else if (load) begin
      state <= SEED_EFF;
    end else if (enable) begin
      state <= lfsr_next(state);
    end else begin
      state <= state;
    end
  end

endmodule
`endif

// File: rtl/button_bounce_gen.sv
// Bouncy-button waveform generator: press-bounce burst, clean hold,
// release-bounce burst, then a one-cycle done pulse. Drives the raw input
// of the keypad debouncer for self-test and loopback.
// Optional feature macro: BUTTON_BOUNCE_GEN_RANDOM_EN (random segment lengths
// from an 8-bit LFSR); without it every bounce segment is one cycle long.
module button_bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int         HOLD_W    = 8,
  parameter int         BCNT_W    = 4,
  parameter int         GAP_W     = 3,
  parameter logic [7:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic              logicclk,
  input  logic              clr,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic [BCNT_W-1:0] bounce_cnt,
  output logic              button_out,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [BCNT_W:0]   GLITCH_ONE = {{BCNT_W{1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_ONE   = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_ZERO  = {HOLD_W{1'b0}};
  localparam logic [BCNT_W-1:0] BCNT_ZERO  = {BCNT_W{1'b0}};
  localparam logic [BCNT_W:0]   GLITCH_ZERO = {(BCNT_W+1){1'b0}};
  localparam logic [GAP_W:0]    SEG_ZERO   = {(GAP_W+1){1'b0}};
  localparam logic [GAP_W:0]    SEG_ONE    = {{GAP_W{1'b0}}, 1'b1};

  bounce_state_t     state_r;
  logic [BCNT_W-1:0] n_r;           // latched glitch count
  logic [HOLD_W-1:0] hold_r;        // latched hold length
  logic [GAP_W:0]    seg_cnt_r;     // cycles left in current segment
  logic [BCNT_W:0]   glitch_cnt_r;  // segments left in current burst
  logic [HOLD_W-1:0] hold_cnt_r;    // cycles left in hold

  logic [GAP_W:0]    seg_len_m1_s;  // length of a newly starting segment, minus one
  logic [BCNT_W:0]   glitch_init_s;
  logic [BCNT_W:0]   glitch_lat_s;
  logic [HOLD_W-1:0] hold_init_s;
  logic [HOLD_W-1:0] hold_lat_s;

`ifdef BUTTON_BOUNCE_GEN_RANDOM_EN
  logic [7:0]       lfsr_s;
  logic [7-GAP_W:0] lfsr_unused_s;

  bounce_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .logicclk(logicclk),
    .clr     (clr),
    .enable  (busy),
    .load    (1'b0),
    .state   (lfsr_s)
  );

  assign seg_len_m1_s  = {1'b0, lfsr_s[GAP_W-1:0]};
  assign lfsr_unused_s = lfsr_s[7:GAP_W];
`else
  logic [7:0] lfsr_seed_unused_s;

  assign seg_len_m1_s       = SEG_ZERO;
  assign lfsr_seed_unused_s = LFSR_SEED;
`endif

  // Reload values: 2N-1 further segments after the first, max(hold,1)-1 further hold cycles.
  always_comb begin
    glitch_init_s = {bounce_cnt, 1'b0} - GLITCH_ONE;
    glitch_lat_s  = {n_r, 1'b0} - GLITCH_ONE;
    if (hold_len == HOLD_ZERO) begin
      hold_init_s = HOLD_ZERO;
    end else begin
      hold_init_s = hold_len - HOLD_ONE;
    end
    if (hold_r == HOLD_ZERO) begin
      hold_lat_s = HOLD_ZERO;
    end else begin
      hold_lat_s = hold_r - HOLD_ONE;
    end
  end

  // Waveform sequencer with registered button level, busy, done and overrun.
  always_ff @(posedge logicclk or posedge clr) begin
    if (clr) begin
      state_r      <= IDLE;
      n_r          <= BCNT_ZERO;
      hold_r       <= HOLD_ZERO;
      seg_cnt_r    <= SEG_ZERO;
      glitch_cnt_r <= GLITCH_ZERO;
      hold_cnt_r   <= HOLD_ZERO;
      button_out   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_r        <= bounce_cnt;
            hold_r     <= hold_len;
            overrun    <= 1'b0;
            busy       <= 1'b1;
            button_out <= 1'b1;
            if (bounce_cnt == BCNT_ZERO) begin
              state_r    <= HOLD;
              hold_cnt_r <= hold_init_s;
            end else begin
              state_r      <= BOUNCE_IN;
              glitch_cnt_r <= glitch_init_s;
              seg_cnt_r    <= seg_len_m1_s;
            end
          end else begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            button_out <= 1'b0;
          end
        end

        BOUNCE_IN: begin
          if (start) begin
            overrun <= 1'b1;
          end else begin
            overrun <= overrun;
          end
          if (seg_cnt_r != SEG_ZERO) begin
            seg_cnt_r <= seg_cnt_r - SEG_ONE;
          end else if (glitch_cnt_r != GLITCH_ZERO) begin
            glitch_cnt_r <= glitch_cnt_r - GLITCH_ONE;
            button_out   <= ~button_out;
            seg_cnt_r    <= seg_len_m1_s;
          end else begin
            state_r    <= HOLD;
            button_out <= 1'b1;
            hold_cnt_r <= hold_lat_s;
          end
        end

        HOLD: begin
          if (start) begin
            overrun <= 1'b1;
          end else begin
            overrun <= overrun;
          end
          if (hold_cnt_r != HOLD_ZERO) begin
            hold_cnt_r <= hold_cnt_r - HOLD_ONE;
          end else if (n_r == BCNT_ZERO) begin
            state_r    <= DONE;
            button_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            state_r      <= BOUNCE_OUT;
            button_out   <= 1'b0;
            glitch_cnt_r <= glitch_lat_s;
            seg_cnt_r    <= seg_len_m1_s;
          end
        end

        BOUNCE_OUT: begin
          if (start) begin
            overrun <= 1'b1;
          end else begin
            overrun <= overrun;
          end
          if (seg_cnt_r != SEG_ZERO) begin
            seg_cnt_r <= seg_cnt_r - SEG_ONE;
          end else if (glitch_cnt_r != GLITCH_ZERO) begin
            glitch_cnt_r <= glitch_cnt_r - GLITCH_ONE;
            button_out   <= ~button_out;
            seg_cnt_r    <= seg_len_m1_s;
          end else begin
            state_r    <= DONE;
            button_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end

        DONE: begin
          // A start seen here is neither accepted nor flagged as overrun.
          state_r    <= IDLE;
          done       <= 1'b0;
          busy       <= 1'b0;
          button_out <= 1'b0;
        end

        default: begin
          state_r    <= IDLE;
          button_out <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_bounce_gen.sv
// Self-checking bench for button_bounce_gen (deterministic build).
module tb_button_bounce_gen;

  logic       logicclk = 1'b0;
  logic       clr;
  logic       start;
  logic [7:0] hold_len;
  logic [3:0] bounce_cnt;
  logic       button_out;
  logic       busy;
  logic       done;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_ovr  = 1'b0;
  bit wave_q[$];
  logic [15:0] cap;

  typedef struct {
    int n;
    int h;
    int exp_done;
  } vec_t;

  vec_t vecs[6];

  button_bounce_gen dut (
    .logicclk  (logicclk),
    .clr       (clr),
    .start     (start),
    .hold_len  (hold_len),
    .bounce_cnt(bounce_cnt),
    .button_out(button_out),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 logicclk = ~logicclk;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // Reference waveform: N high/low pairs, max(H,1) highs, N low/high pairs.
  task automatic model_wave(input int n, input int h);
    wave_q.delete();
    for (int i = 0; i < 2 * n; i++) wave_q.push_back((i % 2) == 0);
    for (int i = 0; i < ((h == 0) ? 1 : h); i++) wave_q.push_back(1'b1);
    for (int i = 0; i < 2 * n; i++) wave_q.push_back((i % 2) == 1);
  endtask

  // Start one waveform and check it cycle by cycle. ovr_at: cycle during which
  // start is raised again; clr_at: cycle at which reset aborts; start_on_done:
  // raise start in the done cycle.
  task automatic run_wave(input int n, input int h, input int ovr_at, input int clr_at,
                          input bit start_on_done, output int done_cyc);
    int len;
    model_wave(n, h);
    len      = wave_q.size();
    done_cyc = -1;
    cap      = 16'h0000;
    @(negedge logicclk);
    start      = 1'b1;
    bounce_cnt = n[3:0];
    hold_len   = h[7:0];
    @(posedge logicclk);
    #1;
    start      = 1'b0;
    bounce_cnt = 4'($urandom);
    hold_len   = 8'($urandom);
    exp_ovr    = 1'b0;
    for (int k = 1; k <= len + 2; k++) begin
      if (k > 1) begin
        @(posedge logicclk);
        #1;
      end
      if (clr_at != 0 && k == clr_at) begin
        clr = 1'b1;
        #1;
        check("abort_button_out", k, button_out, 0);
        check("abort_busy", k, busy, 0);
        check("abort_done", k, done, 0);
        check("abort_overrun", k, overrun, 0);
        @(posedge logicclk);
        #1;
        check("abort_hold_button_out", k + 1, button_out, 0);
        @(negedge logicclk);
        clr = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(posedge logicclk);
          #1;
          check("abort_no_done", k + 2 + j, done, 0);
          check("abort_idle_busy", k + 2 + j, busy, 0);
        end
        exp_ovr  = 1'b0;
        done_cyc = 0;
        return;
      end
      if (k <= len) begin
        check("button_out", k, button_out, wave_q[k-1]);
        check("busy", k, busy, 1);
        check("done", k, done, 0);
        cap = {cap[14:0], button_out};
      end else if (k == len + 1) begin
        check("done_button_out", k, button_out, 0);
        check("done_busy", k, busy, 0);
        check("done_pulse", k, done, 1);
        if (done === 1'b1) done_cyc = k;
      end else begin
        check("idle_button_out", k, button_out, 0);
        check("idle_busy", k, busy, 0);
        check("idle_done", k, done, 0);
      end
      check("overrun", k, overrun, exp_ovr);
      start = (k == ovr_at) || (start_on_done && k == len + 1);
      if (k == ovr_at && k <= len) exp_ovr = 1'b1;
    end
    start = 1'b0;
  endtask

  initial begin
    int dc;
    int n;
    int h;
    clr        = 1'b1;
    start      = 1'b0;
    hold_len   = 8'd0;
    bounce_cnt = 4'd0;
    vecs[0] = '{2, 5, 14};
    vecs[1] = '{0, 0, 2};
    vecs[2] = '{0, 3, 4};
    vecs[3] = '{1, 0, 6};
    vecs[4] = '{3, 10, 23};
    vecs[5] = '{15, 255, 316};

    #12;
    check("reset_button_out", 0, button_out, 0);
    check("reset_busy", 0, busy, 0);
    check("reset_done", 0, done, 0);
    check("reset_overrun", 0, overrun, 0);
    @(negedge logicclk);
    clr = 1'b0;
    @(posedge logicclk);
    #1;
    check("idle_after_reset", 0, busy, 0);

    // Table-driven waveforms with hand-computed done cycles.
    foreach (vecs[i]) begin
      run_wave(vecs[i].n, vecs[i].h, 0, 0, 1'b0, dc);
      check("done_cycle", i, dc, vecs[i].exp_done);
      if (i == 0) check("basic_pattern", 13, {19'd0, cap[12:0]}, {19'd0, 13'b1010111110101});
    end

    // Overrun mid-burst, sticky until the next accepted start.
    run_wave(2, 5, 3, 0, 1'b0, dc);
    check("ovr_done_cycle", 0, dc, 14);
    check("ovr_sticky", 0, overrun, 1);
    run_wave(0, 0, 0, 0, 1'b0, dc);
    check("ovr_cleared", 0, overrun, 0);

    // Overrun on the last busy cycle.
    run_wave(1, 0, 5, 0, 1'b0, dc);
    check("ovr_last_sticky", 0, overrun, 1);

    // Start during the done cycle is ignored.
    run_wave(1, 2, 0, 0, 1'b1, dc);
    check("done_start_ovr", 0, overrun, 0);
    check("done_start_idle", 0, busy, 0);

    // Reset mid-operation, then a full burst.
    run_wave(2, 5, 0, 6, 1'b0, dc);
    run_wave(2, 5, 0, 0, 1'b0, dc);
    check("after_abort_done_cycle", 0, dc, 14);
    check("after_abort_pattern", 13, {19'd0, cap[12:0]}, {19'd0, 13'b1010111110101});

    // Randomised waveforms against the reference model.
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 15);
      h = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 20);
      run_wave(n, h, $urandom_range(0, 12), 0, 1'($urandom_range(0, 1)), dc);
      check("rand_done_cycle", r, dc, 4 * n + ((h == 0) ? 1 : h) + 1);
      repeat ($urandom_range(0, 3)) @(posedge logicclk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
